// File: rtl/gray_fifo_rd_ctrl.sv
// Read-side pointer controller for a Gray-pointer FIFO: synchronizes the write
// pointer, owns the read pointer and produces empty/level/accept/valid/underflow.
module gray_fifo_rd_ctrl #(
    parameter int p_ADDR_WIDTH  = 4,
    parameter int p_SYNC_STAGES = 2
) (
    input  logic                    iw_clk,
    input  logic                    iw_reset,
    input  logic [p_ADDR_WIDTH:0]   iwv_wr_ptr_gray,
    input  logic                    iw_rd_en,
    output logic                    ow_rd_accept,
    output logic [p_ADDR_WIDTH-1:0] owv_rd_addr,
    output logic                    ow_rd_valid,
    output logic [p_ADDR_WIDTH:0]   owv_rd_ptr_gray,
    output logic                    ow_empty,
    output logic [p_ADDR_WIDTH:0]   owv_level,
    output logic                    ow_underflow
);

    localparam int PW = p_ADDR_WIDTH + 1;

    logic [PW-1:0] sync_q [p_SYNC_STAGES];
    logic [PW-1:0] rd_bin_q, rd_bin_d;
    logic [PW-1:0] rd_gray_q, rd_gray_d;
    logic [PW-1:0] level_q, level_d;
    logic [PW-1:0] wr_gray_s_d, wr_bin_s_d;
    logic          empty_q, empty_d;
    logic          valid_q;
    logic          underflow_q;

    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    assign ow_rd_accept = iw_rd_en & ~empty_q & ~iw_reset;

    // Flags are computed from the values about to be registered so that a read
    // and a newly synced write landing on the same edge are both accounted for.
    always_comb begin
        rd_bin_d    = rd_bin_q + PW'(ow_rd_accept);
        rd_gray_d   = rd_bin_d ^ (rd_bin_d >> 1);
        wr_gray_s_d = sync_q[p_SYNC_STAGES-2];
        wr_bin_s_d  = gray2bin(wr_gray_s_d);
        level_d     = wr_bin_s_d - rd_bin_d;
        empty_d     = (rd_gray_d == wr_gray_s_d);
    end

    always_ff @(posedge iw_clk) begin
        if (iw_reset) begin
            for (int i = 0; i < p_SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            rd_bin_q    <= '0;
            rd_gray_q   <= '0;
            level_q     <= '0;
            empty_q     <= 1'b1;
            valid_q     <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            sync_q[0] <= iwv_wr_ptr_gray;
            for (int i = 1; i < p_SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            rd_bin_q    <= rd_bin_d;
            rd_gray_q   <= rd_gray_d;
            level_q     <= level_d;
            empty_q     <= empty_d;
            valid_q     <= ow_rd_accept;
            underflow_q <= iw_rd_en & empty_q;
        end
    end

    assign owv_rd_addr     = rd_bin_q[p_ADDR_WIDTH-1:0];
    assign owv_rd_ptr_gray = rd_gray_q;
    assign owv_level       = level_q;
    assign ow_empty        = empty_q;
    assign ow_rd_valid     = valid_q;
    assign ow_underflow    = underflow_q;

endmodule

// File: tb/tb_gray_fifo_rd_ctrl.sv
// Randomized bench for gray_fifo_rd_ctrl: a word-count model (writes issued,
// reads accepted, sync delay line) predicts every output each cycle.
module tb_gray_fifo_rd_ctrl;

    localparam int AW = 4;
    localparam int PW = AW + 1;
    localparam int S  = 2;

    logic          iw_clk = 1'b0;
    logic          iw_reset;
    logic [PW-1:0] iwv_wr_ptr_gray;
    logic          iw_rd_en;
    logic          ow_rd_accept;
    logic [AW-1:0] owv_rd_addr;
    logic          ow_rd_valid;
    logic [PW-1:0] owv_rd_ptr_gray;
    logic          ow_empty;
    logic [PW-1:0] owv_level;
    logic          ow_underflow;

    always #5 iw_clk = ~iw_clk;

    gray_fifo_rd_ctrl #(.p_ADDR_WIDTH(AW), .p_SYNC_STAGES(S)) dut (
        .iw_clk          (iw_clk),
        .iw_reset        (iw_reset),
        .iwv_wr_ptr_gray (iwv_wr_ptr_gray),
        .iw_rd_en        (iw_rd_en),
        .ow_rd_accept    (ow_rd_accept),
        .owv_rd_addr     (owv_rd_addr),
        .ow_rd_valid     (ow_rd_valid),
        .owv_rd_ptr_gray (owv_rd_ptr_gray),
        .ow_empty        (ow_empty),
        .owv_level       (owv_level),
        .ow_underflow    (ow_underflow)
    );

    int n_vec = 0;
    int n_err = 0;

    // Model state: counts of words written/read and the synchronizer delay.
    logic [PW-1:0] wr_cnt = '0;
    logic [PW-1:0] m_rd, m_level;
    logic          m_empty, m_valid, m_uf;
    logic [PW-1:0] m_d [S-1];
    bit            model_ok = 1'b0;
    logic          acc_seen;
    logic [AW-1:0] addr_seen;

    function automatic logic [PW-1:0] to_gray(input logic [PW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle(input bit rst, input bit rd, input bit winc);
        logic [PW-1:0] diff;
        logic [PW-1:0] w_used;
        logic          m_acc;
        @(negedge iw_clk);
        if (model_ok) begin
            chk("empty",     32'(ow_empty),        32'(m_empty));
            chk("level",     32'(owv_level),       32'(m_level));
            chk("rd_valid",  32'(ow_rd_valid),     32'(m_valid));
            chk("underflow", 32'(ow_underflow),    32'(m_uf));
            chk("rd_gray",   32'(owv_rd_ptr_gray), 32'(to_gray(m_rd)));
        end
        diff = wr_cnt - m_rd;
        if (rst) wr_cnt = '0;
        else if (winc && diff < PW'(16)) wr_cnt = wr_cnt + 1'b1;
        iw_reset        = rst;
        iw_rd_en        = rd;
        iwv_wr_ptr_gray = rst ? PW'($urandom) : to_gray(wr_cnt);
        #1;
        m_acc = rd & ~m_empty & ~rst;
        if (model_ok) begin
            chk("rd_accept", 32'(ow_rd_accept), 32'(m_acc));
            chk("rd_addr",   32'(owv_rd_addr),  32'(m_rd[AW-1:0]));
        end
        acc_seen  = ow_rd_accept;
        addr_seen = owv_rd_addr;
        if (rst) begin
            m_rd = '0; m_level = '0; m_empty = 1'b1; m_valid = 1'b0; m_uf = 1'b0;
            for (int i = 0; i < S - 1; i++) m_d[i] = '0;
            model_ok = 1'b1;
        end else begin
            w_used = m_d[S-2];
            for (int i = S - 2; i > 0; i--) m_d[i] = m_d[i-1];
            m_d[0]  = wr_cnt;
            m_uf    = rd & m_empty;
            m_rd    = m_rd + PW'(m_acc);
            m_level = w_used - m_rd;
            m_empty = (m_level == '0);
            m_valid = m_acc;
        end
        @(posedge iw_clk);
        #2;
    endtask

    initial begin
        iw_reset = 1'b1; iw_rd_en = 1'b0; iwv_wr_ptr_gray = '0;

        repeat (3) cycle(1'b1, 1'($urandom), 1'b0);
        chk("rst_empty", 32'(ow_empty), 32'd1);
        chk("rst_level", 32'(owv_level), 32'd0);
        chk("rst_gray",  32'(owv_rd_ptr_gray), 32'd0);
        chk("rst_valid", 32'(ow_rd_valid), 32'd0);
        chk("rst_uf",    32'(ow_underflow), 32'd0);
        chk("rst_acc",   32'(acc_seen), 32'd0);

        // single word, two-edge sync latency
        cycle(1'b0, 1'b0, 1'b1);
        chk("sw_lvl_edge1", 32'(owv_level), 32'd0);
        cycle(1'b0, 1'b0, 1'b0);
        chk("sw_lvl_edge2", 32'(owv_level), 32'd1);
        chk("sw_empty",     32'(ow_empty), 32'd0);
        cycle(1'b0, 1'b1, 1'b0);
        chk("sw_acc",   32'(acc_seen), 32'd1);
        chk("sw_addr",  32'(addr_seen), 32'd0);
        chk("sw_valid", 32'(ow_rd_valid), 32'd1);
        chk("sw_gray",  32'(owv_rd_ptr_gray), 32'd1);
        chk("sw_empty2",32'(ow_empty), 32'd1);

        // full then drain
        cycle(1'b1, 1'b0, 1'b0);
        repeat (16) cycle(1'b0, 1'b0, 1'b1);
        chk("full_wrgray", 32'(iwv_wr_ptr_gray), 32'b11000);
        repeat (2) cycle(1'b0, 1'b0, 1'b0);
        chk("full_level", 32'(owv_level), 32'd16);
        for (int i = 0; i < 16; i++) begin
            cycle(1'b0, 1'b1, 1'b0);
            chk("drain_addr",  32'(addr_seen), 32'(i));
            chk("drain_valid", 32'(ow_rd_valid), 32'd1);
            chk("drain_uf",    32'(ow_underflow), 32'd0);
        end
        chk("drain_empty", 32'(ow_empty), 32'd1);

        // underflow pulse
        cycle(1'b0, 1'b1, 1'b0);
        chk("uf_acc",   32'(acc_seen), 32'd0);
        chk("uf_pulse", 32'(ow_underflow), 32'd1);
        chk("uf_gray",  32'(owv_rd_ptr_gray), 32'b11000);
        cycle(1'b0, 1'b0, 1'b0);
        chk("uf_clear", 32'(ow_underflow), 32'd0);

        // simultaneous read and synced write arrival
        repeat (3) cycle(1'b0, 1'b0, 1'b1);
        repeat (2) cycle(1'b0, 1'b0, 1'b0);
        chk("sim_lvl3", 32'(owv_level), 32'd3);
        cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 1'b0);
        chk("sim_level", 32'(owv_level), 32'd3);
        chk("sim_empty", 32'(ow_empty), 32'd0);

        // random interleave, wraps the pointers several times
        repeat (400) cycle(1'b0, 1'($urandom_range(1)), ($urandom_range(2) != 0));

        // reset mid-stream
        cycle(1'b1, 1'b0, 1'b0);
        repeat (5) cycle(1'b0, 1'b0, 1'b1);
        repeat (2) cycle(1'b0, 1'b0, 1'b0);
        chk("mid_level5", 32'(owv_level), 32'd5);
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b0);
        chk("mid_acc",   32'(acc_seen), 32'd0);
        chk("mid_empty", 32'(ow_empty), 32'd1);
        chk("mid_level", 32'(owv_level), 32'd0);
        chk("mid_gray",  32'(owv_rd_ptr_gray), 32'd0);
        chk("mid_valid", 32'(ow_rd_valid), 32'd0);
        cycle(1'b0, 1'b0, 1'b0);
        chk("mid_valid2", 32'(ow_rd_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/gray_fifo_rd_ctrl.md
Name: gray_fifo_rd_ctrl

Overview:
Read-side pointer controller for a Gray-pointer FIFO. It consumes the Gray-coded write pointer produced by a Gray increment counter in the write domain, synchronizes it, and decodes it to binary. It maintains the local read pointer in binary and Gray, and generates empty, level, read address, read-valid and underflow. It sits between the FIFO storage RAM (synchronous read, 1-cycle latency) and the downstream consumer; its Gray read pointer goes back to the write side.

Parameters:
p_ADDR_WIDTH, 4, RAM address width; depth = 2^p_ADDR_WIDTH; pointers are p_ADDR_WIDTH+1 bits; must be >= 1.
p_SYNC_STAGES, 2, flip-flops in the write-pointer synchronizer chain; must be >= 2.

Ports:
iw_clk  input  1  clock; single clock domain; all state updates on rising edge.
iw_reset  input  1  synchronous, active-high reset.
iwv_wr_ptr_gray  input  p_ADDR_WIDTH+1  Gray-coded write pointer, asynchronous to iw_clk; changes at most 1 bit per update.
iw_rd_en  input  1  consumer read request.
ow_rd_accept  output  1  combinational: iw_rd_en & ~ow_empty & ~iw_reset; RAM read enable.
owv_rd_addr  output  p_ADDR_WIDTH  RAM read address = rd_bin[p_ADDR_WIDTH-1:0].
ow_rd_valid  output  1  registered; RAM data valid (1 cycle after accept).
owv_rd_ptr_gray  output  p_ADDR_WIDTH+1  registered Gray read pointer, to write side.
ow_empty  output  1  registered empty flag.
owv_level  output  p_ADDR_WIDTH+1  registered count of unread words, 0..2^p_ADDR_WIDTH.
ow_underflow  output  1  registered 1-cycle pulse: read requested while empty.

Behaviour:
- Reset (iw_reset=1 at edge): sync chain = 0, rd_bin = 0, owv_rd_ptr_gray = 0, ow_empty = 1, owv_level = 0, ow_rd_valid = 0, ow_underflow = 0. Reset mid-operation discards all state on the next edge. ow_rd_accept is forced to 0 while iw_reset is high.
- Synchronizer: iwv_wr_ptr_gray passes through p_SYNC_STAGES flops. The last stage is decoded Gray->binary with a prefix-XOR from the MSB, giving wr_bin_s. No logic sits between the input port and the first flop.
- Read pointer: rd_bin_next = rd_bin + ow_rd_accept, computed modulo 2^(p_ADDR_WIDTH+1), so it wraps all-ones -> 0. owv_rd_ptr_gray <= rd_bin_next ^ (rd_bin_next >> 1). Registering guarantees the Gray output changes exactly 1 bit per accept and never glitches.
- Level/empty, registered from next-state values:
  - owv_level <= wr_bin_s_next - rd_bin_next, modulo 2^(p_ADDR_WIDTH+1). wr_bin_s_next is the decode of the value entering the last sync stage.
  - ow_empty <= (gray(rd_bin_next) == last-stage-next Gray).
  - ow_empty == (owv_level == 0) in every cycle.
- Latency:
  - A write-pointer change at the input is reflected in ow_empty/owv_level on the p_SYNC_STAGES-th rising edge (2 edges by default).
  - An accepted read updates owv_rd_ptr_gray, owv_level and ow_empty on the same edge.
  - ow_rd_valid = accept delayed 1 cycle.
- Simultaneous accept and write-pointer advance in one cycle: level unchanged, empty stays 0.
- Last-word read: after the edge, ow_empty = 1 unless a synced write arrives on the same edge.
- Underflow: iw_rd_en & ow_empty causes ow_underflow = 1 for exactly one cycle. The pointer is unchanged and ow_rd_valid stays 0. This is not sticky.
- Write-side protocol violation: a level > 2^p_ADDR_WIDTH (more than 1 Gray bit changing) is not detected; the output is undefined.
- Empty is pessimistic: it may stay asserted for extra cycles after a write, but must never deassert while the FIFO is actually empty.

Test Plan:
- Reset: hold iw_reset 3 cycles with random iwv_wr_ptr_gray -> ow_empty=1, owv_level=0, owv_rd_ptr_gray=0, ow_rd_valid=0, ow_underflow=0, ow_rd_accept=0.
- Single word (defaults): wr gray 00000->00001 -> ow_empty=0, owv_level=1 exactly 2 edges later. Then iw_rd_en 1 cycle -> ow_rd_accept=1, addr 0, next edge ow_rd_valid=1, owv_rd_ptr_gray=00001, ow_empty=1, level=0.
- Full: walk wr gray to binary 16 (gray 11000) -> owv_level=16. Then 16 back-to-back reads -> addr 0..15 in order, ow_rd_valid continuous 16 cycles, empty after the last read, no underflow.
- Wrap: run 40 writes/reads interleaved -> rd_bin passes 31->0, owv_rd_ptr_gray 10000->00000. Scoreboard level = writes-reads every cycle; Gray output changes 1 bit per accept.
- Underflow / simultaneous: iw_rd_en while empty -> ow_underflow 1-cycle pulse, pointer unchanged. With level=3, read and wr-pointer advance on the same cycle -> level stays 3.
- Reset mid-stream: level=5, assert iw_reset mid-burst with iw_rd_en=1 -> next edge all outputs at reset values, no ow_rd_valid after the reset edge.
